// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit.
//   - lsu_state_t    : access sequencing states
//   - LSU_B/H/W/BU/HU: funct3 size/sign encodings
//   - LSU_BE_W       : byte-enable width of the data bus
//   - helpers        : size decode, byte-enable and store-lane generation
package lsu_pkg;

  localparam int REG_BUS  = 32;
  localparam int LSU_BE_W = 4;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_t;

  // Unlisted funct3 codes fall back to a full word access.
  function automatic lsu_size_t lsu_size(input logic [2:0] f3);
    case (f3)
      LSU_B, LSU_BU: return SZ_B;
      LSU_H, LSU_HU: return SZ_H;
      default:       return SZ_W;
    endcase
  endfunction

  function automatic logic [LSU_BE_W-1:0] lsu_be(input logic [2:0] f3, input logic [1:0] off);
    case (lsu_size(f3))
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the store operand across all lanes; byte enables pick the live one.
  function automatic logic [REG_BUS-1:0] lsu_store_data(input logic [2:0] f3, input logic [REG_BUS-1:0] wd);
    case (lsu_size(f3))
      SZ_B:    return {4{wd[7:0]}};
      SZ_H:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/dm_load_align.sv
// Combinational load-data aligner.
//   rdata    in  32  raw word from the data bus
//   offset   in   2  byte offset of the access within the word
//   funct3   in   3  size/sign encoding of the load
//   load_data out 32 lane-shifted, sign/zero-extended result
module dm_load_align
  import lsu_pkg::*;
(
  input  logic [REG_BUS-1:0] rdata,
  input  logic [1:0]         offset,
  input  logic [2:0]         funct3,
  output logic [REG_BUS-1:0] load_data
);

  logic [REG_BUS-1:0] shifted_s;

  // Bring the addressed byte/half down to bit 0, then extend.
  always_comb begin
    shifted_s = rdata >> {offset, 3'b000};
    case (funct3)
      LSU_B:   load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
      LSU_H:   load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
      LSU_BU:  load_data = {24'h000000, shifted_s[7:0]};
      LSU_HU:  load_data = {16'h0000, shifted_s[15:0]};
      default: load_data = shifted_s;
    endcase
  end

endmodule

// File: rtl/dm_lsu.sv
// Memory-stage load/store unit: issues one valid/ready bus request per
// load/store, stalls the pipeline until the single response beat arrives,
// and returns extended load data with a one-cycle completion pulse.
//   clk, reset(active-low async)          clock / reset
//   m_mem_read, m_mem_write, m_funct3,
//   m_addr, m_wdata                        memory-stage instruction
//   stall, misaligned                      combinational pipeline controls
//   load_valid, load_data                  completion towards writeback
//   dbus_req_*                             registered bus request
//   dbus_rsp_valid, dbus_rsp_rdata         bus response
module dm_lsu
  import lsu_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                m_mem_read,
  input  logic                m_mem_write,
  input  logic [2:0]          m_funct3,
  input  logic [REG_BUS-1:0]  m_addr,
  input  logic [REG_BUS-1:0]  m_wdata,
  output logic                stall,
  output logic                misaligned,
  output logic                load_valid,
  output logic [REG_BUS-1:0]  load_data,
  output logic                dbus_req_valid,
  input  logic                dbus_req_ready,
  output logic                dbus_req_we,
  output logic [REG_BUS-1:0]  dbus_req_addr,
  output logic [REG_BUS-1:0]  dbus_req_wdata,
  output logic [LSU_BE_W-1:0] dbus_req_be,
  input  logic                dbus_rsp_valid,
  input  logic [REG_BUS-1:0]  dbus_rsp_rdata
);

  lsu_state_t         state_r;
  lsu_state_t         next_state_s;
  logic               access_s;
  logic               misaligned_s;
  logic               start_s;
  logic               stall_s;
  logic [2:0]         funct3_r;
  logic [1:0]         off_r;
  logic [REG_BUS-1:0] align_s;

  assign access_s   = m_mem_read | m_mem_write;
  assign stall      = stall_s;
  assign misaligned = misaligned_s;

  // Alignment check on the incoming instruction.
  always_comb begin
    misaligned_s = 1'b0;
    case (lsu_size(m_funct3))
      SZ_H:    misaligned_s = access_s & m_addr[0];
      SZ_W:    misaligned_s = access_s & (m_addr[1:0] != 2'b00);
      default: misaligned_s = 1'b0;
    endcase
  end

  // Next-state and stall decode.
  always_comb begin
    next_state_s = state_r;
    stall_s      = 1'b0;
    start_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (access_s && !misaligned_s) begin
          next_state_s = ST_REQ;
          stall_s      = 1'b1;
          start_s      = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
          stall_s      = 1'b0;
          start_s      = 1'b0;
        end
      end
      ST_REQ: begin
        stall_s = 1'b1;
        if (dbus_req_ready) begin
          next_state_s = ST_RESP;
        end else begin
          next_state_s = ST_REQ;
        end
      end
      ST_RESP: begin
        stall_s = 1'b1;
        if (dbus_rsp_valid) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_RESP;
        end
      end
      // Stall drops here so the instruction retires at the end of DONE
      // and IDLE sees the next one, never a re-issue.
      ST_DONE: begin
        next_state_s = ST_IDLE;
        stall_s      = 1'b0;
      end
      default: begin
        next_state_s = ST_IDLE;
        stall_s      = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  dm_load_align u_align (
    .rdata     (dbus_rsp_rdata),
    .offset    (off_r),
    .funct3    (funct3_r),
    .load_data (align_s)
  );

  // Request fields and load result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dbus_req_valid <= 1'b0;
      dbus_req_we    <= 1'b0;
      dbus_req_addr  <= 32'h0000_0000;
      dbus_req_wdata <= 32'h0000_0000;
      dbus_req_be    <= 4'b0000;
      funct3_r       <= 3'b000;
      off_r          <= 2'b00;
      load_valid     <= 1'b0;
      load_data      <= 32'h0000_0000;
    end else begin
      load_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            dbus_req_valid <= 1'b1;
            dbus_req_we    <= m_mem_write;
            dbus_req_addr  <= {m_addr[31:2], 2'b00};
            dbus_req_wdata <= lsu_store_data(m_funct3, m_wdata);
            dbus_req_be    <= lsu_be(m_funct3, m_addr[1:0]);
            funct3_r       <= m_funct3;
            off_r          <= m_addr[1:0];
          end
        end
        ST_REQ: begin
          if (dbus_req_ready) begin
            dbus_req_valid <= 1'b0;
          end
        end
        ST_RESP: begin
          // Stores finish silently; only loads produce a completion pulse.
          if (dbus_rsp_valid && !dbus_req_we) begin
            load_valid <= 1'b1;
            load_data  <= align_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_lsu.sv
module tb_dm_lsu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m_mem_read = 1'b0;
  logic        m_mem_write = 1'b0;
  logic [2:0]  m_funct3 = 3'b000;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_wdata = 32'h0;
  logic        stall, misaligned, load_valid;
  logic [31:0] load_data;
  logic        dbus_req_valid;
  logic        dbus_req_ready = 1'b0;
  logic        dbus_req_we;
  logic [31:0] dbus_req_addr, dbus_req_wdata;
  logic [3:0]  dbus_req_be;
  logic        dbus_rsp_valid = 1'b0;
  logic [31:0] dbus_rsp_rdata = 32'h0;

  int checks = 0;
  int failures = 0;

  int          obs_stall, obs_req_cycles, obs_accept, obs_lv;
  logic [31:0] obs_addr, obs_wdata, obs_ldata;
  logic [3:0]  obs_be;
  logic        obs_we, obs_mis, obs_unstable, obs_timeout;
  int          idle_req, idle_lv, idle_stall;

  dm_lsu dut (
    .clk(clk), .reset(reset),
    .m_mem_read(m_mem_read), .m_mem_write(m_mem_write), .m_funct3(m_funct3),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .stall(stall), .misaligned(misaligned),
    .load_valid(load_valid), .load_data(load_data),
    .dbus_req_valid(dbus_req_valid), .dbus_req_ready(dbus_req_ready),
    .dbus_req_we(dbus_req_we), .dbus_req_addr(dbus_req_addr),
    .dbus_req_wdata(dbus_req_wdata), .dbus_req_be(dbus_req_be),
    .dbus_rsp_valid(dbus_rsp_valid), .dbus_rsp_rdata(dbus_rsp_rdata)
  );

  always #5 clk = ~clk;

  // Present one instruction and act as the bus until the stall drops.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int ready_delay, input logic [31:0] rdata);
    int req_seen = 0;
    bit pending = 0;
    bit done = 0;
    obs_stall = 0; obs_req_cycles = 0; obs_accept = 0; obs_lv = 0;
    obs_addr = 32'h0; obs_wdata = 32'h0; obs_ldata = 32'h0; obs_be = 4'h0;
    obs_we = 1'b0; obs_mis = 1'b0; obs_unstable = 1'b0; obs_timeout = 1'b0;
    @(posedge clk); #1;
    m_mem_read = rd; m_mem_write = wr; m_funct3 = f3; m_addr = addr; m_wdata = wdata;
    dbus_req_ready = 1'b0; dbus_rsp_valid = 1'b0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      if (cyc != 0) begin
        @(posedge clk); #1;
        dbus_rsp_valid = pending;
        dbus_rsp_rdata = pending ? rdata : 32'h0;
        pending = 0;
        dbus_req_ready = dbus_req_valid && (req_seen >= ready_delay);
      end
      @(negedge clk);
      if (cyc == 0) obs_mis = misaligned;
      if (stall) obs_stall++;
      if (dbus_req_valid) begin
        if (req_seen == 0) begin
          obs_addr = dbus_req_addr; obs_wdata = dbus_req_wdata;
          obs_be = dbus_req_be; obs_we = dbus_req_we;
        end else if (obs_addr !== dbus_req_addr || obs_wdata !== dbus_req_wdata ||
                     obs_be !== dbus_req_be || obs_we !== dbus_req_we) begin
          obs_unstable = 1'b1;
        end
        req_seen++;
        obs_req_cycles++;
        if (dbus_req_ready) begin
          obs_accept++;
          pending = 1;
        end
      end
      if (load_valid) begin
        obs_lv++;
        obs_ldata = load_data;
      end
      if (!stall) done = 1;
    end
    if (!done) obs_timeout = 1'b1;
  endtask

  // Drop the instruction and watch the unit for n quiet cycles.
  task automatic idle_cycles(input int n);
    idle_req = 0; idle_lv = 0; idle_stall = 0;
    @(posedge clk); #1;
    m_mem_read = 1'b0; m_mem_write = 1'b0;
    dbus_req_ready = 1'b0; dbus_rsp_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (dbus_req_valid) idle_req++;
      if (load_valid) idle_lv++;
      if (stall) idle_stall++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({stall, misaligned, dbus_req_valid, dbus_req_we, load_valid} !== 5'b00000) begin failures++; $display("FAIL reset_ctl got=%b exp=00000", {stall, misaligned, dbus_req_valid, dbus_req_we, load_valid}); end
    checks++; if ({dbus_req_addr, dbus_req_wdata, load_data} !== 96'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", {dbus_req_addr, dbus_req_wdata, load_data}); end
    checks++; if (dbus_req_be !== 4'b0000) begin failures++; $display("FAIL reset_be got=%b exp=0000", dbus_req_be); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({stall, dbus_req_valid, load_valid} !== 3'b000) begin failures++; $display("FAIL reset_release got=%b exp=000", {stall, dbus_req_valid, load_valid}); end
  endtask

  task automatic test_lw();
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF);
    checks++; if (obs_timeout !== 1'b0) begin failures++; $display("FAIL lw_timeout got=%b exp=0", obs_timeout); end
    checks++; if (obs_stall !== 3) begin failures++; $display("FAIL lw_stall got=%0d exp=3", obs_stall); end
    checks++; if (obs_addr !== 32'h0000_0100) begin failures++; $display("FAIL lw_addr got=%h exp=00000100", obs_addr); end
    checks++; if (obs_be !== 4'b1111) begin failures++; $display("FAIL lw_be got=%b exp=1111", obs_be); end
    checks++; if (obs_we !== 1'b0) begin failures++; $display("FAIL lw_we got=%b exp=0", obs_we); end
    checks++; if (obs_lv !== 1) begin failures++; $display("FAIL lw_lvalid got=%0d exp=1", obs_lv); end
    checks++; if (obs_ldata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lw_data got=%h exp=deadbeef", obs_ldata); end
    checks++; if (obs_accept !== 1) begin failures++; $display("FAIL lw_accept got=%0d exp=1", obs_accept); end
  endtask

  task automatic test_load_ext();
    run_access(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 0, 32'h8011_2233);
    checks++; if (obs_ldata !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_data got=%h exp=ffffff80", obs_ldata); end
    checks++; if (obs_be !== 4'b1000) begin failures++; $display("FAIL lb_be got=%b exp=1000", obs_be); end
    checks++; if (obs_addr !== 32'h0000_0100) begin failures++; $display("FAIL lb_addr got=%h exp=00000100", obs_addr); end
    run_access(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 0, 32'h8011_2233);
    checks++; if (obs_ldata !== 32'h0000_0080) begin failures++; $display("FAIL lbu_data got=%h exp=00000080", obs_ldata); end
    run_access(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 0, 32'h8001_1234);
    checks++; if (obs_ldata !== 32'hFFFF_8001) begin failures++; $display("FAIL lh_data got=%h exp=ffff8001", obs_ldata); end
    checks++; if (obs_be !== 4'b1100) begin failures++; $display("FAIL lh_be got=%b exp=1100", obs_be); end
    run_access(1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0, 0, 32'h1234_8001);
    checks++; if (obs_ldata !== 32'h0000_8001) begin failures++; $display("FAIL lhu_data got=%h exp=00008001", obs_ldata); end
  endtask

  task automatic test_sh_delayed();
    run_access(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 4, 32'h0);
    checks++; if (obs_be !== 4'b1100) begin failures++; $display("FAIL sh_be got=%b exp=1100", obs_be); end
    checks++; if (obs_wdata !== 32'hABCD_ABCD) begin failures++; $display("FAIL sh_wdata got=%h exp=abcdabcd", obs_wdata); end
    checks++; if (obs_we !== 1'b1) begin failures++; $display("FAIL sh_we got=%b exp=1", obs_we); end
    checks++; if (obs_unstable !== 1'b0) begin failures++; $display("FAIL sh_stable got=%b exp=0", obs_unstable); end
    checks++; if (obs_req_cycles !== 5) begin failures++; $display("FAIL sh_req_cycles got=%0d exp=5", obs_req_cycles); end
    checks++; if (obs_stall !== 7) begin failures++; $display("FAIL sh_stall got=%0d exp=7", obs_stall); end
    checks++; if (obs_lv !== 0) begin failures++; $display("FAIL sh_lvalid got=%0d exp=0", obs_lv); end
  endtask

  task automatic test_misaligned();
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 0, 32'h0);
    checks++; if (obs_mis !== 1'b1) begin failures++; $display("FAIL mis_flag got=%b exp=1", obs_mis); end
    checks++; if (obs_stall !== 0) begin failures++; $display("FAIL mis_stall got=%0d exp=0", obs_stall); end
    checks++; if (obs_req_cycles !== 0) begin failures++; $display("FAIL mis_req got=%0d exp=0", obs_req_cycles); end
    idle_cycles(3);
    checks++; if (idle_req !== 0) begin failures++; $display("FAIL mis_idle_req got=%0d exp=0", idle_req); end
  endtask

  task automatic test_reset_mid_resp();
    @(posedge clk); #1;
    m_mem_read = 1'b1; m_mem_write = 1'b0; m_funct3 = 3'b010;
    m_addr = 32'h0000_0300; m_wdata = 32'h5555_5555;
    @(posedge clk); #1;
    dbus_req_ready = 1'b1;
    @(negedge clk);
    checks++; if (dbus_req_valid !== 1'b1) begin failures++; $display("FAIL rst_req_valid got=%b exp=1", dbus_req_valid); end
    @(posedge clk); #1;
    dbus_req_ready = 1'b0;
    reset = 1'b0;
    m_mem_read = 1'b0;
    @(negedge clk);
    checks++; if ({stall, dbus_req_valid, dbus_req_we, load_valid} !== 4'b0000) begin failures++; $display("FAIL rst_mid_ctl got=%b exp=0000", {stall, dbus_req_valid, dbus_req_we, load_valid}); end
    checks++; if ({dbus_req_addr, dbus_req_wdata, load_data} !== 96'h0) begin failures++; $display("FAIL rst_mid_data got=%h exp=0", {dbus_req_addr, dbus_req_wdata, load_data}); end
    checks++; if (dbus_req_be !== 4'b0000) begin failures++; $display("FAIL rst_mid_be got=%b exp=0000", dbus_req_be); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    dbus_rsp_valid = 1'b1; dbus_rsp_rdata = 32'hCAFE_F00D;
    idle_cycles(4);
    checks++; if (idle_lv !== 0) begin failures++; $display("FAIL rst_stale_lv got=%0d exp=0", idle_lv); end
    checks++; if (idle_req + idle_stall !== 0) begin failures++; $display("FAIL rst_stale_busy got=%0d exp=0", idle_req + idle_stall); end
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0, 0, 32'h0BAD_F00D);
    checks++; if (obs_stall !== 3) begin failures++; $display("FAIL rst_after_stall got=%0d exp=3", obs_stall); end
    checks++; if (obs_ldata !== 32'h0BAD_F00D) begin failures++; $display("FAIL rst_after_data got=%h exp=0badf00d", obs_ldata); end
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 0, 32'h1234_5678);
    checks++; if (obs_accept !== 1) begin failures++; $display("FAIL b2b_lw_accept got=%0d exp=1", obs_accept); end
    checks++; if (obs_ldata !== 32'h1234_5678) begin failures++; $display("FAIL b2b_lw_data got=%h exp=12345678", obs_ldata); end
    run_access(1'b0, 1'b1, 3'b000, 32'h0000_0205, 32'h0000_007F, 1, 32'h0);
    checks++; if (obs_accept !== 1) begin failures++; $display("FAIL b2b_sb_accept got=%0d exp=1", obs_accept); end
    checks++; if (obs_addr !== 32'h0000_0204) begin failures++; $display("FAIL b2b_sb_addr got=%h exp=00000204", obs_addr); end
    checks++; if (obs_be !== 4'b0010) begin failures++; $display("FAIL b2b_sb_be got=%b exp=0010", obs_be); end
    checks++; if (obs_wdata !== 32'h7F7F_7F7F) begin failures++; $display("FAIL b2b_sb_wdata got=%h exp=7f7f7f7f", obs_wdata); end
    checks++; if (obs_we !== 1'b1) begin failures++; $display("FAIL b2b_sb_we got=%b exp=1", obs_we); end
    checks++; if (obs_stall !== 4) begin failures++; $display("FAIL b2b_sb_stall got=%0d exp=4", obs_stall); end
    idle_cycles(4);
    checks++; if (idle_req !== 0) begin failures++; $display("FAIL b2b_dup_req got=%0d exp=0", idle_req); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_sh_delayed();
    test_misaligned();
    test_reset_mid_resp();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
